// File: rtl/req_seq_monitor.sv
// Synthesizable checker for "req1 ##DELAY req2": one check per accepted arm pulse,
// one-cycle pass/fail result and saturating tallies. Optional fail_code via REQ_SEQ_MON_FAILCODE_EN.
module req_seq_monitor #(
  parameter int DELAY    = 2,
  parameter int WAIT_MAX = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             req1,
  input  logic             req2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef REQ_SEQ_MON_FAILCODE_EN
  ,
  output logic [1:0]       fail_code
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_R1 = 2'd1;
  localparam logic [1:0] DLY     = 2'd2;

  localparam int WAIT_W = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int DLY_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(DELAY - 1);
  localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1);
  localparam logic [DLY_W-1:0]  DLY_ZERO  = {DLY_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic [DLY_W-1:0]  dly_cnt_r;
  logic [DLY_W-1:0]  dly_nxt_s;
  logic              decide_s;
  logic              pass_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_ONE;
    end
  endfunction

  // Next-state logic; decide_s marks the edge that settles the running check.
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    dly_nxt_s   = dly_cnt_r;
    decide_s    = 1'b0;
    pass_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (arm) begin
          state_nxt_s = WAIT_R1;
          wait_nxt_s  = WAIT_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT_R1: begin
        if (req1) begin
          state_nxt_s = DLY;
          dly_nxt_s   = DLY_LOAD;
        end else if (wait_cnt_r == WAIT_ZERO) begin
          state_nxt_s = IDLE;
          decide_s    = 1'b1;
          pass_s      = 1'b0;
        end else begin
          wait_nxt_s  = wait_cnt_r - WAIT_ONE;
        end
      end
      DLY: begin
        // req1/req2 between the two sample edges are deliberately ignored.
        if (dly_cnt_r == DLY_ZERO) begin
          state_nxt_s = IDLE;
          decide_s    = 1'b1;
          pass_s      = req2;
        end else begin
          dly_nxt_s   = dly_cnt_r - DLY_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and sequencing counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      wait_cnt_r <= WAIT_ZERO;
      dly_cnt_r  <= DLY_ZERO;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      dly_cnt_r  <= dly_nxt_s;
    end
  end

  // Registered status and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      busy <= (state_nxt_s != IDLE);
      done <= decide_s;
      pass <= decide_s & pass_s;
      fail <= decide_s & ~pass_s;
    end
  end

  // Saturating tallies, updated at the deciding edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= {CNT_W{1'b0}};
      fail_cnt <= {CNT_W{1'b0}};
    end else if (decide_s) begin
      if (pass_s) begin
        pass_cnt <= sat_inc(pass_cnt);
      end else begin
        fail_cnt <= sat_inc(fail_cnt);
      end
    end else begin
      pass_cnt <= pass_cnt;
      fail_cnt <= fail_cnt;
    end
  end

`ifdef REQ_SEQ_MON_FAILCODE_EN
  // Failure cause: a decision taken in WAIT_R1 can only mean req1 never came.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_code <= 2'b00;
    end else if (decide_s) begin
      if (pass_s) begin
        fail_code <= 2'b00;
      end else if (state_r == WAIT_R1) begin
        fail_code <= 2'b01;
      end else begin
        fail_code <= 2'b10;
      end
    end else begin
      fail_code <= fail_code;
    end
  end
`endif

endmodule

// File: tb/tb_req_seq_monitor.sv
// Directed bench for req_seq_monitor: a vector table on a strict instance (WAIT_MAX=0),
// hand sequences on a WAIT_MAX=3 / CNT_W=2 instance for waiting, saturation and mid-check reset.
module tb_req_seq_monitor;

  typedef struct {
    logic arm;
    logic req1;
    logic req2;
    int   busy;
    int   done;
    int   pass;
    int   fail;
    int   pcnt;
    int   fcnt;
    int   code;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_arm = 1'b0, a_req1 = 1'b0, a_req2 = 1'b0;
  logic b_arm = 1'b0, b_req1 = 1'b0, b_req2 = 1'b0;
  logic a_busy, a_done, a_pass, a_fail;
  logic b_busy, b_done, b_pass, b_fail;
  logic [7:0] a_pass_cnt, a_fail_cnt;
  logic [1:0] b_pass_cnt, b_fail_cnt;
  logic [1:0] a_fail_code, b_fail_code;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  req_seq_monitor #(.DELAY(2), .WAIT_MAX(0), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .arm(a_arm), .req1(a_req1), .req2(a_req2),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail(a_fail),
    .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt)
`ifdef REQ_SEQ_MON_FAILCODE_EN
    , .fail_code(a_fail_code)
`endif
  );

  req_seq_monitor #(.DELAY(2), .WAIT_MAX(3), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .arm(b_arm), .req1(b_req1), .req2(b_req2),
    .busy(b_busy), .done(b_done), .pass(b_pass), .fail(b_fail),
    .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt)
`ifdef REQ_SEQ_MON_FAILCODE_EN
    , .fail_code(b_fail_code)
`endif
  );

`ifndef REQ_SEQ_MON_FAILCODE_EN
  assign a_fail_code = 2'b00;
  assign b_fail_code = 2'b00;
`endif

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic arm, input logic r1, input logic r2, input int busy,
                     input int done, input int pass, input int fail, input int pc,
                     input int fc, input int code);
    vec_t v;
    v.arm = arm; v.req1 = r1; v.req2 = r2;
    v.busy = busy; v.done = done; v.pass = pass; v.fail = fail;
    v.pcnt = pc; v.fcnt = fc; v.code = code;
    vecs.push_back(v);
  endtask

  // One B cycle: drive at negedge, sample 1 time unit after the posedge.
  task automatic b_cycle(input logic arm, input logic r1, input logic r2);
    @(negedge clk);
    b_arm = arm; b_req1 = r1; b_req2 = r2;
    @(posedge clk);
    #1;
  endtask

  task automatic b_expect(input string name, input int busy, input int done, input int pass,
                          input int pc, input int fc);
    check({name, ".busy"}, int'(b_busy), busy);
    check({name, ".done"}, int'(b_done), done);
    check({name, ".pass"}, int'(b_pass), pass);
    check({name, ".fail"}, int'(b_fail), done & ~pass & 1);
    check({name, ".pass_cnt"}, int'(b_pass_cnt), pc);
    check({name, ".fail_cnt"}, int'(b_fail_cnt), fc);
  endtask

  initial begin
    // Test 1: arm, req1 next edge, req2 DELAY edges later -> pass
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 1, 0, 0);
    add(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 0, 0);
    // Test 2: req1 absent with strict semantics -> fail code 01
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1, 0, 0);
    add(1'b0, 1'b0, 1'b0, 0, 1, 0, 1, 1, 1, 1);
    add(1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 1, 1, 1);
    // Test 3: early req2 ignored, req2 low at DELAY -> fail code 10
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1, 1, 1);
    add(1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 1, 1, 1);
    add(1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 1, 1, 1);
    add(1'b0, 1'b0, 1'b0, 0, 1, 0, 1, 1, 2, 2);
    add(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1, 2, 2);
    // Test 5: arm while busy ignored, arm in done cycle accepted, req1 in DLY no restart
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1, 2, 2);
    add(1'b1, 1'b1, 1'b0, 1, 0, 0, 0, 1, 2, 2);
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1, 2, 2);
    add(1'b1, 1'b0, 1'b1, 0, 1, 1, 0, 2, 2, 0);
    add(1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 2, 2, 0);
    add(1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 2, 2, 0);
    add(1'b0, 1'b1, 1'b0, 1, 0, 0, 0, 2, 2, 0);
    add(1'b0, 1'b0, 1'b1, 0, 1, 1, 0, 3, 2, 0);
    add(1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 3, 2, 0);
    add(1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 3, 2, 0);

    // Reset for 3 cycles; outputs must already be cleared.
    repeat (3) @(posedge clk);
    #1;
    check("rst.a_busy", int'(a_busy), 0);
    check("rst.a_done", int'(a_done), 0);
    check("rst.a_pass", int'(a_pass), 0);
    check("rst.a_fail", int'(a_fail), 0);
    check("rst.a_pass_cnt", int'(a_pass_cnt), 0);
    check("rst.a_fail_cnt", int'(a_fail_cnt), 0);
    check("rst.b_busy", int'(b_busy), 0);
    check("rst.b_done", int'(b_done), 0);
`ifdef REQ_SEQ_MON_FAILCODE_EN
    check("rst.a_fail_code", int'(a_fail_code), 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      a_arm = vecs[i].arm; a_req1 = vecs[i].req1; a_req2 = vecs[i].req2;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.busy", i), int'(a_busy), vecs[i].busy);
      check($sformatf("vec%0d.done", i), int'(a_done), vecs[i].done);
      check($sformatf("vec%0d.pass", i), int'(a_pass), vecs[i].pass);
      check($sformatf("vec%0d.fail", i), int'(a_fail), vecs[i].fail);
      check($sformatf("vec%0d.pass_cnt", i), int'(a_pass_cnt), vecs[i].pcnt);
      check($sformatf("vec%0d.fail_cnt", i), int'(a_fail_cnt), vecs[i].fcnt);
`ifdef REQ_SEQ_MON_FAILCODE_EN
      check($sformatf("vec%0d.fail_code", i), int'(a_fail_code), vecs[i].code);
`endif
    end
    @(negedge clk);
    a_arm = 1'b0; a_req1 = 1'b0; a_req2 = 1'b0;

    // Test 4a: WAIT_MAX=3, req1 first seen at k+3, req2 at k+5 -> pass
    b_cycle(1'b1, 1'b0, 1'b0); b_expect("w4a.k", 1, 0, 0, 0, 0);
    b_cycle(1'b0, 1'b0, 1'b0); b_expect("w4a.k1", 1, 0, 0, 0, 0);
    b_cycle(1'b0, 1'b0, 1'b0); b_expect("w4a.k2", 1, 0, 0, 0, 0);
    b_cycle(1'b0, 1'b1, 1'b0); b_expect("w4a.k3", 1, 0, 0, 0, 0);
    b_cycle(1'b0, 1'b0, 1'b0); b_expect("w4a.k4", 1, 0, 0, 0, 0);
    b_cycle(1'b0, 1'b0, 1'b1); b_expect("w4a.k5", 0, 1, 1, 1, 0);

    // Test 4b: req1 never high -> fail at k+1+WAIT_MAX
    b_cycle(1'b1, 1'b0, 1'b0); b_expect("w4b.k", 1, 0, 0, 1, 0);
    for (int j = 1; j <= 3; j++) begin
      b_cycle(1'b0, 1'b0, 1'b1);
      b_expect($sformatf("w4b.k%0d", j), 1, 0, 0, 1, 0);
    end
    b_cycle(1'b0, 1'b0, 1'b0); b_expect("w4b.k4", 0, 1, 0, 1, 1);
`ifdef REQ_SEQ_MON_FAILCODE_EN
    check("w4b.fail_code", int'(b_fail_code), 1);
`endif

    // Test 6: five passes on a 2-bit counter saturate at 3
    for (int p = 0; p < 5; p++) begin
      b_cycle(1'b1, 1'b0, 1'b0);
      b_cycle(1'b0, 1'b1, 1'b0);
      b_cycle(1'b0, 1'b0, 1'b0);
      b_cycle(1'b0, 1'b0, 1'b1);
      b_expect($sformatf("sat%0d", p), 0, 1, 1, (p + 2 > 3) ? 3 : p + 2, 1);
    end
    b_cycle(1'b0, 1'b0, 1'b0); b_expect("sat.hold", 0, 0, 0, 3, 1);

    // Reset in DLY: abandon check, clear counters immediately, never report done
    b_cycle(1'b1, 1'b0, 1'b0);
    b_cycle(1'b0, 1'b1, 1'b0);
    b_expect("rdly.pre", 1, 0, 0, 3, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    b_expect("rdly.async", 0, 0, 0, 0, 0);
    check("rdly.a_pass_cnt", int'(a_pass_cnt), 0);
    check("rdly.a_fail_cnt", int'(a_fail_cnt), 0);
    b_cycle(1'b0, 1'b0, 1'b1); b_expect("rdly.held", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b_cycle(1'b0, 1'b0, 1'b1); b_expect("rdly.rel1", 0, 0, 0, 0, 0);
    b_cycle(1'b0, 1'b0, 1'b1); b_expect("rdly.rel2", 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
